// File: rtl/usb_rx_ctrl_pkg.sv
// lycan_globals: shared word width, packet field positions and the USB read-side
// state encoding used by usb_rx_ctrl.
package lycan_globals;

    localparam int USB_WORD_W  = 32;
    localparam int PKT_CHAN_HI = 31;
    localparam int PKT_CHAN_LO = 29;

    typedef enum logic [1:0] {
        IDLE,
        OE,
        READ,
        TURN
    } usb_rx_state_t;

endpackage

// File: rtl/usb_rx_ctrl_if.sv
// FT601 read-side bus pins plus the downstream valid/ready word stream.
interface usb_rx_ctrl_if;
    import lycan_globals::*;

    logic [USB_WORD_W-1:0] usb_data;
    logic [3:0]            usb_be;
    logic                  usb_rx_empty;
    logic                  usb_outen_l;
    logic                  usb_rden_l;
    logic [USB_WORD_W-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  usb_data, usb_be, usb_rx_empty, m_ready,
        output usb_outen_l, usb_rden_l, m_data, m_valid
    );

    modport slave (
        output usb_data, usb_be, usb_rx_empty, m_ready,
        input  usb_outen_l, usb_rden_l, m_data, m_valid
    );

endinterface

// File: rtl/usb_rx_ctrl_fifo.sv
// usb_rx_fifo: synchronous first-word-fall-through buffer with occupancy output.
// Storage is not reset; only pointers and count are, so reset discards contents.
module usb_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;

    assign pop  = rd_en && (count != '0);
    assign push = wr_en && ((count != FULL) || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Head word is forced to zero when empty so m_data is defined after reset.
    assign valid   = (count != '0);
    assign rd_data = valid ? mem[rd_ptr] : '0;
    assign level   = count;

endmodule

// File: rtl/usb_rx_ctrl.sv
// FT601 245-mode read controller feeding a FWFT buffer and a valid/ready stream.
// Optional USB_RX_BE_CHECK_EN drops partial words (usb_be != 4'hF) and counts them.
module usb_rx_ctrl
    import lycan_globals::*;
#(
    parameter int DEPTH    = 8,
    parameter int HEADROOM = 2
) (
    input  logic                   clk,
    input  logic                   rst_l,
    usb_rx_ctrl_if.master          bus,
    input  logic                   tx_busy,
    output logic                   rx_busy,
    output logic [15:0]            err_cnt,
    output logic [$clog2(DEPTH):0] level
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FILL_MAX = LW'(DEPTH - HEADROOM);

    usb_rx_state_t state, state_nxt;
    logic          outen_l_q, rden_l_q, outen_nxt, rden_nxt;
    logic          cap, be_ok, wr_en, rd_en, room_now, room_after;
    logic [LW:0]   level_after;

    assign cap = !rden_l_q && !bus.usb_rx_empty;
`ifdef USB_RX_BE_CHECK_EN
    assign be_ok = (bus.usb_be == 4'hF);
`else
    logic be_unused;
    assign be_ok     = 1'b1;
    assign be_unused = ^bus.usb_be;
`endif
    assign wr_en = cap && be_ok;
    assign rd_en = bus.m_valid && bus.m_ready;

    // Free-slot tests are done on occupancy: free >= HEADROOM <=> level <= DEPTH-HEADROOM.
    assign level_after = {1'b0, level} + {{LW{1'b0}}, wr_en} - {{LW{1'b0}}, rd_en};
    assign room_now    = (level <= FILL_MAX);
    assign room_after  = (level_after <= {1'b0, FILL_MAX});

    usb_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (USB_WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .wr_en   (wr_en),
        .wr_data (bus.usb_data),
        .rd_en   (rd_en),
        .rd_data (bus.m_data),
        .valid   (bus.m_valid),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            outen_l_q <= 1'b1;
            rden_l_q  <= 1'b1;
        end else begin
            state     <= state_nxt;
            outen_l_q <= outen_nxt;
            rden_l_q  <= rden_nxt;
        end
    end

    // Strobe values are decided one cycle ahead so the pins come straight off flops.
    always_comb begin
        state_nxt = state;
        outen_nxt = 1'b1;
        rden_nxt  = 1'b1;
        case (state)
            IDLE: begin
                if (!bus.usb_rx_empty && !tx_busy && room_now) begin
                    state_nxt = OE;
                    outen_nxt = 1'b0;
                end
            end
            OE: begin
                state_nxt = READ;
                outen_nxt = 1'b0;
                rden_nxt  = 1'b0;
            end
            READ: begin
                if (bus.usb_rx_empty || !room_after) begin
                    state_nxt = TURN;
                end else begin
                    outen_nxt = 1'b0;
                    rden_nxt  = 1'b0;
                end
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_busy         = (state != IDLE);
    assign bus.usb_outen_l = outen_l_q;
    assign bus.usb_rden_l  = rden_l_q;

`ifdef USB_RX_BE_CHECK_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err_cnt <= '0;
        end else if (cap && !be_ok && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Bench for usb_rx_ctrl: mock FT601 read FIFO, queue-based scoreboard, directed and
// randomized traffic. Expectations follow USB_RX_BE_CHECK_EN when it is defined.
module tb_usb_rx_ctrl;
    localparam int DEPTH    = 8;
    localparam int HEADROOM = 2;
    localparam int LW       = $clog2(DEPTH) + 1;
`ifdef USB_RX_BE_CHECK_EN
    localparam bit BE_CHECK = 1'b1;
`else
    localparam bit BE_CHECK = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst_l   = 1'b0;
    logic          tx_busy = 1'b0;
    logic          rx_busy;
    logic [15:0]   err_cnt;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    usb_rx_ctrl_if bus ();

    usb_rx_ctrl #(
        .DEPTH    (DEPTH),
        .HEADROOM (HEADROOM)
    ) dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .bus     (bus),
        .tx_busy (tx_busy),
        .rx_busy (rx_busy),
        .err_cnt (err_cnt),
        .level   (level)
    );

    logic [35:0] src_q[$];    // words waiting in the mock USB FIFO: {be, data}
    logic [31:0] sb_q[$];     // words expected to be held in the DUT buffer, in order
    bit          hold_empty = 1'b0;
    int          n_chk = 0, n_err = 0;
    int          n_cap = 0, n_recv = 0, n_bursts = 0, exp_err = 0;
    logic        prev_outen = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int n, input int bad_idx);
        for (int i = 0; i < n; i++)
            src_q.push_back({(i == bad_idx) ? 4'h3 : 4'hF, 32'($urandom())});
    endtask

    task automatic drain(input int budget, input string tag);
        int k = 0;
        while ((src_q.size() != 0 || sb_q.size() != 0 || rx_busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(k < budget), 32'd1);
    endtask

    // Bus-level reference: a capture is any edge with rden_l=0 and rx_empty=0.
    always @(posedge clk) begin
        logic        hs, cap;
        logic [35:0] w;
        if (rst_l) begin
            hs  = bus.m_valid && bus.m_ready;
            cap = !bus.usb_rden_l && !bus.usb_rx_empty;
            if (hs) begin
                if (sb_q.size() == 0) begin
                    check_eq("m_valid_model_empty", 32'(bus.m_valid), 32'd0);
                end else begin
                    check_eq("m_data_handshake", bus.m_data, sb_q[0]);
                    void'(sb_q.pop_front());
                    n_recv++;
                end
            end
            if (cap && src_q.size() != 0) begin
                w = src_q.pop_front();
                n_cap++;
                if (BE_CHECK && w[35:32] != 4'hF) begin
                    if (exp_err < 65535) exp_err++;
                end else begin
                    sb_q.push_back(w[31:0]);
                end
            end
        end
        if (prev_outen && !bus.usb_outen_l) n_bursts++;
        prev_outen = bus.usb_outen_l;
    end

    // Per-cycle state checks, then the mock FIFO drives its pins for the next edge.
    always @(negedge clk) begin
        #1;
        if (rst_l) begin
            check_eq("level", 32'(level), 32'(sb_q.size()));
            check_eq("m_valid", 32'(bus.m_valid), 32'(sb_q.size() != 0));
            if (sb_q.size() != 0) check_eq("m_data_head", bus.m_data, sb_q[0]);
            else                  check_eq("m_data_empty", bus.m_data, 32'd0);
            check_eq("err_cnt", 32'(err_cnt), 32'(exp_err));
            if (!bus.usb_rden_l) check_eq("outen_during_read", 32'(bus.usb_outen_l), 32'd0);
            if (!rx_busy) check_eq("idle_strobes", 32'({bus.usb_outen_l, bus.usb_rden_l}), 32'd3);
        end
        if (src_q.size() != 0 && !hold_empty) begin
            {bus.usb_be, bus.usb_data} = src_q[0];
            bus.usb_rx_empty = 1'b0;
        end else begin
            bus.usb_be       = 4'h0;
            bus.usb_data     = '0;
            bus.usb_rx_empty = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_oe, t_rd, t_off, t_c1, t_cl, pc, c0, r0, b0, k, oe_cnt, lvl_rise, nw;
        bit seen, got;
        bus.m_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_outen", 32'(bus.usb_outen_l), 32'd1);
        check_eq("rst_rden", 32'(bus.usb_rden_l), 32'd1);
        check_eq("rst_rx_busy", 32'(rx_busy), 32'd0);
        check_eq("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_eq("rst_m_data", bus.m_data, 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);

        // Eight-word burst with downstream always ready
        bus.m_ready = 1'b1;
        load(8, -1);
        c0 = n_cap; r0 = n_recv; pc = n_cap;
        t_oe = -1; t_rd = -1; t_off = -1; t_c1 = -1; t_cl = -1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (t_oe < 0 && !bus.usb_outen_l) begin
                t_oe = t;
                check_eq("t1_oe_cycle_rden", 32'(bus.usb_rden_l), 32'd1);
            end
            if (t_rd < 0 && !bus.usb_rden_l) t_rd = t;
            if (t_oe >= 0 && t_off < 0 && bus.usb_outen_l) t_off = t;
            if (n_cap != pc) begin
                if (t_c1 < 0) t_c1 = t;
                t_cl = t;
            end
            pc = n_cap;
        end
        check_eq("t1_rd_after_oe", 32'(t_rd - t_oe), 32'd1);
        check_eq("t1_first_capture", 32'(t_c1 - t_oe), 32'd2);
        check_eq("t1_captures", 32'(n_cap - c0), 32'd8);
        check_eq("t1_capture_span", 32'(t_cl - t_c1), 32'd7);
        check_eq("t1_oe_release", 32'(t_off >= 10 && t_off <= 11), 32'd1);
        check_eq("t1_words_out", 32'(n_recv - r0), 32'd8);

        // Backpressure: downstream stalled, buffer must stop the burst without loss
        bus.m_ready = 1'b0;
        load(8, -1);
        c0 = n_cap; r0 = n_recv; seen = 0; got = 0; lvl_rise = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!bus.usb_rden_l) seen = 1;
            else if (seen && !got) begin
                got = 1;
                lvl_rise = int'(level);
            end
            if (got && !rx_busy) break;
        end
        check_eq("t2_rden_rose", 32'(got), 32'd1);
        check_eq("t2_level_le7", 32'(lvl_rise <= 7), 32'd1);
        check_eq("t2_captured_held", 32'(n_cap - c0), 32'(lvl_rise));
        repeat (5) @(negedge clk);
        check_eq("t2_stays_idle", 32'(rx_busy), 32'd0);
        bus.m_ready = 1'b1;
        drain(80, "t2_drain");
        check_eq("t2_words_out", 32'(n_recv - r0), 32'd8);

        // Write side owns the bus
        tx_busy = 1'b1;
        load(8, -1);
        oe_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.usb_outen_l) oe_cnt++;
        end
        check_eq("t3_no_oe", 32'(oe_cnt), 32'd0);
        tx_busy = 1'b0;
        @(negedge clk);
        check_eq("t3_oe_next_cycle", 32'(bus.usb_outen_l), 32'd0);
        drain(80, "t3_drain");

        // rx_empty high for one cycle after word 2
        b0 = n_bursts; r0 = n_recv;
        load(2, -1);
        k = 0;
        while (src_q.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check_eq("t4_first_two", 32'(k < 30), 32'd1);
        @(negedge clk);
        load(6, -1);
        drain(80, "t4_drain");
        check_eq("t4_words_out", 32'(n_recv - r0), 32'd8);
        check_eq("t4_bursts", 32'(n_bursts - b0), 32'd2);

        // Reset mid-burst after four captures
        b0 = n_bursts; c0 = n_cap;
        load(8, -1);
        k = 0;
        while (n_cap - c0 < 4 && k < 30) begin
            @(negedge clk);
            k++;
        end
        rst_l = 1'b0;
        sb_q.delete();
        exp_err = 0;
        #1;
        check_eq("t5_rden_async", 32'(bus.usb_rden_l), 32'd1);
        check_eq("t5_outen_async", 32'(bus.usb_outen_l), 32'd1);
        check_eq("t5_level", 32'(level), 32'd0);
        check_eq("t5_m_valid", 32'(bus.m_valid), 32'd0);
        check_eq("t5_rx_busy", 32'(rx_busy), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        check_eq("t5_restart_oe", 32'(bus.usb_outen_l), 32'd0);
        check_eq("t5_restart_rd", 32'(bus.usb_rden_l), 32'd1);
        drain(80, "t5_drain");
        check_eq("t5_bursts", 32'(n_bursts - b0), 32'd2);
        check_eq("t5_bus_words", 32'(n_cap - c0), 32'd8);

        // Partial word at index 3
        r0 = n_recv;
        load(8, 3);
        drain(80, "t6_drain");
        check_eq("t6_words_out", 32'(n_recv - r0), BE_CHECK ? 32'd7 : 32'd8);
        check_eq("t6_err_cnt", 32'(err_cnt), BE_CHECK ? 32'd1 : 32'd0);

        // Randomized traffic, stalls, write-side holds and empty gaps
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            tx_busy     = ($urandom_range(0, 9) == 0);
            hold_empty  = ($urandom_range(0, 15) == 0);
            if (src_q.size() < 4 && $urandom_range(0, 5) == 0) begin
                nw = int'($urandom_range(1, 6));
                for (int j = 0; j < nw; j++)
                    src_q.push_back({($urandom_range(0, 7) == 0) ? 4'h7 : 4'hF, 32'($urandom())});
            end
        end
        bus.m_ready = 1'b1;
        tx_busy     = 1'b0;
        hold_empty  = 1'b0;
        drain(300, "t7_drain");
        check_eq("t7_model_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
